cla_mul_seq: RTL and testbench

//   Multi-cycle 16x16 -> 32-bit multiplier sequencer for the RISC ALU. Shift-add multiplier

---
 rtl/cla_mul_seq_pkg.sv | 25 ++
 rtl/cla_mul_seq_cla16bit.sv | 48 ++++
 rtl/cla_mul_seq.sv | 176 +++++++++++++++++
 tb/tb_cla_mul_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cla_mul_seq_pkg.sv
// Shared constants and types for the shift-add multiplier sequencer.
// Holds the sequencer state encoding, datapath width and the ALU opcodes that launch it.
package cla_mul_seq_pkg;

    localparam int ALU_W = 16;

    typedef enum logic [2:0] {
        MS_IDLE   = 3'd0,
        MS_ABS_A  = 3'd1,
        MS_ABS_B  = 3'd2,
        MS_MUL    = 3'd3,
        MS_NEG_LO = 3'd4,
        MS_NEG_HI = 3'd5,
        MS_DONE   = 3'd6
    } ms_state_t;

    // ALU control raises start for these two opcodes.
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_MULS = 4'hB;

    function automatic logic [ALU_W-1:0] cond_inv(input logic [ALU_W-1:0] x, input logic inv);
        return inv ? ~x : x;
    endfunction

endpackage

// File: rtl/cla_mul_seq_cla16bit.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups under a second lookahead level.
// Purely combinational, single-cycle path; no flow control.
module cla16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        cin,
    output logic [15:0] SUM,
    output logic        C_OUT
);

    logic [3:0] w_grp_g;
    logic [3:0] w_grp_p;
    logic [3:0] w_grp_c;

    assign w_grp_c[0] = cin;
    assign w_grp_c[1] = w_grp_g[0] | (w_grp_p[0] & cin);
    assign w_grp_c[2] = w_grp_g[1] | (w_grp_p[1] & w_grp_g[0])
                      | (w_grp_p[1] & w_grp_p[0] & cin);
    assign w_grp_c[3] = w_grp_g[2] | (w_grp_p[2] & w_grp_g[1])
                      | (w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                      | (w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & cin);
    assign C_OUT      = w_grp_g[3] | (w_grp_p[3] & w_grp_g[2])
                      | (w_grp_p[3] & w_grp_p[2] & w_grp_g[1])
                      | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                      | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & cin);

    for (genvar k = 0; k < 4; k++) begin : g_grp
        logic [3:0] w_g;
        logic [3:0] w_p;
        logic [3:0] w_c;

        assign w_g = A[4*k+3:4*k] & B[4*k+3:4*k];
        assign w_p = A[4*k+3:4*k] ^ B[4*k+3:4*k];

        assign w_c[0] = w_grp_c[k];
        assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
        assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
        assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                      | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);

        assign SUM[4*k+3:4*k] = w_p ^ w_c;

        assign w_grp_g[k] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                          | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        assign w_grp_p[k] = &w_p;
    end

endmodule

// File: rtl/cla_mul_seq.sv
// Multi-cycle 16x16->32 shift-add multiplier (unsigned or two's complement) on one shared CLA.
// Latency fixed: done 17 cycles after start (unsigned), 21 (signed); start while busy is dropped.
module cla_mul_seq
    import cla_mul_seq_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_op,
    input  logic               clear,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    ms_state_t          r_state;
    ms_state_t          w_next;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_signed;
    logic               r_sgn;
    logic               r_cy;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_add_a;
    logic [WIDTH-1:0]   w_add_b;
    logic               w_add_cin;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_neg_a;
    logic               w_neg_b;
    logic               w_last;
    logic [2*WIDTH-1:0] w_shifted;

    assign w_neg_a   = r_signed & r_mcand[WIDTH-1];
    assign w_neg_b   = r_signed & r_mplier[WIDTH-1];
    assign w_last    = (r_cnt == CNT_W'(WIDTH-1));
    // One shift-add step: carry out lands in the acc MSB, adder LSB drops into the multiplier.
    assign w_shifted = {w_cout, w_sum, r_mplier[WIDTH-1:1]};

    cla16bit u_add (
        .A     (w_add_a),
        .B     (w_add_b),
        .cin   (w_add_cin),
        .SUM   (w_sum),
        .C_OUT (w_cout)
    );

    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        case (r_state)
            MS_ABS_A: begin
                w_add_a   = cond_inv(r_mcand, w_neg_a);
                w_add_cin = w_neg_a;
            end
            MS_ABS_B: begin
                w_add_a   = cond_inv(r_mplier, w_neg_b);
                w_add_cin = w_neg_b;
            end
            MS_MUL: begin
                w_add_a = r_acc;
                w_add_b = r_mplier[0] ? r_mcand : '0;
            end
            MS_NEG_LO: begin
                w_add_a   = cond_inv(r_mplier, r_sgn);
                w_add_cin = r_sgn;
            end
            MS_NEG_HI: begin
                w_add_a   = cond_inv(r_acc, r_sgn);
                w_add_cin = r_sgn & r_cy;
            end
            default: begin
                w_add_a   = '0;
                w_add_b   = '0;
                w_add_cin = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = MS_IDLE;
        end else begin
            case (r_state)
                MS_IDLE:   if (start) w_next = signed_op ? MS_ABS_A : MS_MUL;
                MS_ABS_A:  w_next = MS_ABS_B;
                MS_ABS_B:  w_next = MS_MUL;
                MS_MUL:    if (w_last) w_next = r_signed ? MS_NEG_LO : MS_DONE;
                MS_NEG_LO: w_next = MS_NEG_HI;
                MS_NEG_HI: w_next = MS_DONE;
                MS_DONE:   w_next = MS_IDLE;
                default:   w_next = MS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MS_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_signed  <= 1'b0;
            r_sgn     <= 1'b0;
            r_cy      <= 1'b0;
            r_product <= '0;
        end else if (!clear) begin
            case (r_state)
                MS_IDLE: begin
                    if (start) begin
                        r_mcand  <= op_a;
                        r_mplier <= op_b;
                        r_signed <= signed_op;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_sgn    <= 1'b0;
                        r_cy     <= 1'b0;
                    end
                end
                MS_ABS_A: begin
                    r_mcand <= w_sum;
                    r_sgn   <= r_signed & (r_mcand[WIDTH-1] ^ r_mplier[WIDTH-1]);
                end
                MS_ABS_B: begin
                    r_mplier <= w_sum;
                end
                MS_MUL: begin
                    {r_acc, r_mplier} <= w_shifted;
                    r_cnt             <= r_cnt + 1'b1;
                    // Unsigned results are published on entry to DONE so they are valid with done.
                    if (w_last && !r_signed) begin
                        r_product <= w_shifted;
                    end
                end
                MS_NEG_LO: begin
                    r_mplier <= w_sum;
                    r_cy     <= w_cout;
                end
                MS_NEG_HI: begin
                    r_acc     <= w_sum;
                    r_product <= {w_sum, r_mplier};
                end
                MS_DONE: begin
                    r_product <= {r_acc, r_mplier};
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign busy    = (r_state != MS_IDLE);
    assign done    = (r_state == MS_DONE);
    assign product = r_product;

endmodule

// File: tb/tb_cla_mul_seq.sv
// Directed bench for cla_mul_seq: product values, fixed latency, busy window, ignore/abort/reset.
module tb_cla_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic        clear;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cla_mul_seq #(.WIDTH(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .clear     (clear),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called in an IDLE cycle; start is sampled at the next edge (cycle 0).
    // Walks cycles 1..ncyc, optionally poking start or clear at a given cycle.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input int lat, input int ncyc, input int restart_cyc, input int clear_cyc,
                          output int done_cyc, output int ndone, output logic [31:0] prod,
                          output int busy_bad);
        logic exp_busy;
        done_cyc = -1;
        ndone    = 0;
        prod     = 32'hDEAD_BEEF;
        busy_bad = 0;
        start     = 1'b1;
        op_a      = a;
        op_b      = b;
        signed_op = s;
        @(posedge clk); #1;
        op_a = ~a;
        op_b = ~b;
        for (int k = 1; k <= ncyc; k++) begin
            start = 1'b0;
            clear = 1'b0;
            if (k == restart_cyc) begin
                start     = 1'b1;
                op_a      = 16'hFFFF;
                op_b      = 16'hFFFF;
                signed_op = ~s;
            end
            if (k == clear_cyc) clear = 1'b1;
            if (done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    prod     = product;
                end
            end
            exp_busy = (k <= lat) && (clear_cyc < 0 || k <= clear_cyc);
            if (busy !== exp_busy) busy_bad++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        clear = 1'b0;
    endtask

    task automatic op_check(input string nm, input logic [15:0] a, input logic [15:0] b,
                            input logic s, input logic [31:0] exp_prod, input int restart_cyc);
        int          dc, nd, bb, lat;
        logic [31:0] pr;
        lat = s ? 21 : 17;
        run_op(a, b, s, lat, lat, restart_cyc, -1, dc, nd, pr, bb);
        check({nm, "_prod"}, pr, exp_prod);
        check({nm, "_done_cycle"}, 32'(dc), 32'(lat));
        check({nm, "_done_count"}, 32'(nd), 32'd1);
        check({nm, "_busy_window"}, 32'(bb), 32'd0);
        check({nm, "_idle_after"}, {30'd0, busy, done}, 32'd0);
        check({nm, "_prod_hold"}, product, exp_prod);
    endtask

    initial begin
        int          dc, nd, bb, cnt_done, cnt_busy;
        logic [31:0] pr;

        rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; clear = 1'b0;
        op_a = 16'h0; op_b = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {30'd0, busy, done}, 32'd0);
        check("reset_product", product, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op_check("u_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, -1);
        op_check("s_m3_x_5",    16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1, -1);
        op_check("s_7_x_m6",    16'h0007, 16'hFFFA, 1'b1, 32'hFFFF_FFD6, -1);
        op_check("s_8000_sq",   16'h8000, 16'h8000, 1'b1, 32'h4000_0000, -1);
        op_check("u_8000_sq",   16'h8000, 16'h8000, 1'b0, 32'h4000_0000, -1);
        op_check("s_8000_x_1",  16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000, -1);

        // Restart attempt at cycle 5 must be dropped.
        op_check("u_restart_ignored", 16'h1234, 16'h0010, 1'b0, 32'h0001_2340, 5);

        // Abort at cycle 8: no done, product keeps the previous result.
        run_op(16'h00FF, 16'h00FF, 1'b0, 17, 20, -1, 8, dc, nd, pr, bb);
        check("clear_no_done", 32'(nd), 32'd0);
        check("clear_busy_window", 32'(bb), 32'd0);
        check("clear_prod_kept", product, 32'h0001_2340);

        // Back-to-back: second op starts in the cycle right after the first done.
        op_check("b2b_zero",  16'h0000, 16'h1234, 1'b0, 32'h0000_0000, -1);
        op_check("b2b_3_x_4", 16'h0003, 16'h0004, 1'b0, 32'h0000_000C, -1);

        // Reset asserted during MUL cycle 10.
        start = 1'b1; op_a = 16'h1234; op_b = 16'h5678; signed_op = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midop_reset_outputs", {30'd0, busy, done}, 32'd0);
        check("midop_reset_product", product, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt_done = 0;
        cnt_busy = 0;
        for (int k = 0; k < 25; k++) begin
            if (done) cnt_done++;
            if (busy) cnt_busy++;
            @(posedge clk); #1;
        end
        check("post_reset_no_done", 32'(cnt_done), 32'd0);
        check("post_reset_no_busy", 32'(cnt_busy), 32'd0);

        // clear and start together in IDLE: clear wins.
        start = 1'b1; clear = 1'b1; op_a = 16'h0003; op_b = 16'h0003; signed_op = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0;
        check("clear_start_idle", {31'd0, busy}, 32'd0);
        cnt_done = 0;
        for (int k = 0; k < 25; k++) begin
            if (done || busy) cnt_done++;
            @(posedge clk); #1;
        end
        check("clear_start_no_activity", 32'(cnt_done), 32'd0);
        check("clear_start_prod", product, 32'd0);

        op_check("final_s_m1_x_m1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
